pipe_ctrl_seq: RTL and testbench
================================

// Module: pipe_ctrl_seq
// PURPOSE
//  Registered ID-stage controller for the 5-stage MIPS pipeline. Decodes the ID instruction into a
//  control bundle, latches it into ID/EX, and owns hazard sequencing: load-use stall, branch/jump
//  flush and a multi-cycle MULT/DIV busy tracker. Sits between IF/ID and ID/EX registers.
// PARAMETERS
//  MULDIV_LAT  4  cycles a mult/div occupies the HI/LO unit after md_start (legal 1..255)
//  REG_AW      5  register-address width
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      asynchronous, active-low reset
//  id_instr       in   32     instruction in ID
//  id_valid       in   1      id_instr is a real instruction (0 = bubble)
//  branch_taken   in   1      beq resolved taken in EX this cycle
//  pc_src         out  2      00 PC+4, 01 branch, 10 j/jal, 11 jr/jalr
//  pc_stall       out  1      hold PC
//  if_id_stall    out  1      hold IF/ID
//  if_id_flush    out  1      zero IF/ID on next edge
//  ex_reg_wr, ex_mem_wr, ex_mem_rd, ex_alu_src_a, ex_alu_src_b, ex_ext_op, ex_lui_op, ex_branch
//                 out  1 ea   registered ID/EX controls
//  ex_alu_op      out  4      registered; [3]=opcode[0]; [2:0] R 010, beq 001, andi 100, slti/u 101, else 000
//  ex_mem_to_reg  out  2      00 ALU, 01 mem, 10 PC+8 (jal)
//  ex_reg_dst     out  2      00 rt, 01 rd, 10 $ra
//  ex_rt          out  REG_AW registered rt field of EX instruction
//  md_start       out  1      one-cycle pulse: mult/div entered EX
//  md_op          out  2      funct[1:0] of that mult/div (00 mult,01 multu,10 div,11 divu)
//  md_busy        out  1      HI/LO unit occupied
// BEHAVIOUR
//  Reset (async, reset==0): all ex_* 0, md_start 0, md_busy 0, FSM MD_IDLE, md_cnt 0; comb outputs follow.
//  Decode (comb): opcodes 00 R, 02 j, 03 jal, 04 beq, 08 addi, 09 addiu, 0a slti, 0b sltiu,
//   0c andi, 0f lui, 23 lw, 2b sw. reg_wr: R-type except funct 08 (jr) and 18-1b (mult/div);
//   plus 03,08,09,0a,0b,0c,0f,23. alu_src_b: 08,09,0a,0b,0c,0f,23,2b. alu_src_a: R with funct 00/02/03.
//   ext_op = opcode!=0c; lui_op = opcode==0f. Unknown opcode or id_valid=0 -> bubble (all ctrl 0).
//  Load-use: hz_lu = ex_mem_rd & (ex_rt!=0) & (ex_rt==rs | (ex_rt==rt & uses_rt)); uses_rt = R, beq, sw.
//  MD hazard: hz_md = md_busy & ID is mfhi(10)/mflo(12)/mult/div (18-1b).
//  Priority per cycle: branch_taken > (hz_md | hz_lu) > jump > normal.
//   branch_taken: pc_src=01, if_id_flush=1, ID/EX <= bubble, no stall (EX/ID instrs killed).
//   stall: pc_stall=if_id_stall=1, ID/EX <= bubble, pc_src=00, no flush.
//   jump in ID (02/03 or R funct 08/09): pc_src 10/11, if_id_flush=1, ID/EX <= decoded jump ctrl.
//   normal: ID/EX <= decoded ctrl, pc_src 00.
//  Latency: decode->ex_* exactly 1 cycle; hazard outputs combinational, same cycle as cause.
//  MD FSM: MD_IDLE, MD_BUSY. When a mult/div is loaded into ID/EX (not stalled/flushed):
//   md_start=1 next cycle, md_op latched, md_cnt<=MULDIV_LAT-1; if that is 0 stay MD_IDLE, else MD_BUSY.
//   MD_BUSY: md_cnt decrements each cycle; at md_cnt==1 -> MD_IDLE next edge. md_busy = (state==MD_BUSY).
//   Branch flush during MD_BUSY does NOT abort; only reset does. md_cnt width $clog2(MULDIV_LAT+1).
//  Simultaneous md completion and mfhi in ID: stall in the cycle md_busy=1, proceed the next.
//  $zero target never triggers load-use. Reset mid-stall/mid-busy: returns to idle, no md_start.
// STRUCTURE
//  ctrl_pkg: opcode/funct localparams, PC_SRC_*, MEM2REG_*, REGDST_*, MD_IDLE/MD_BUSY encodings.
//  Sub-module ctrl_decode (pure comb opcode/funct -> ctrl bundle); pipe_ctrl_seq adds
//  hazard logic, ID/EX register and MD FSM/counter.
// TESTING
//  1 lw $t0 then add $t1,$t0,$t2 -> 1 cycle pc_stall=if_id_stall=1, ex_reg_wr=0 bubble, add issues next.
//  2 lw $0 then add using $0 -> no stall.
//  3 beq with branch_taken=1 while lw-use pending in ID -> pc_src=01, flush=1, no stall.
//  4 mult (LAT=4) then mflo -> md_start 1 pulse, md_busy 3 cycles, mflo stalled exactly 3 cycles.
//  5 jal 0x0040 -> pc_src=10, flush=1; next cycle ex_reg_dst=10, ex_mem_to_reg=10, ex_reg_wr=1.
//  6 reset low mid MD_BUSY and mid stall -> all ex_* 0, md_busy 0 immediately (async).

Source files
------------

// File: rtl/pipe_ctrl_seq_pkg.sv
// Shared encodings for the ID-stage pipeline controller: opcodes, functs,
// PC-select / writeback / destination codes, MD FSM states and the control bundle.
package pipe_ctrl_seq_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    // mult/multu/div/divu occupy 0x18..0x1b, i.e. funct[5:2] == 4'b0110
    localparam logic [3:0] FN_MD_HI = 4'b0110;

    localparam logic [1:0] PC_SRC_PC4    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_JREG   = 2'b11;

    localparam logic [1:0] MEM2REG_ALU = 2'b00;
    localparam logic [1:0] MEM2REG_MEM = 2'b01;
    localparam logic [1:0] MEM2REG_PC8 = 2'b10;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    typedef struct packed {
        logic       reg_wr;
        logic       mem_wr;
        logic       mem_rd;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       ext_op;
        logic       lui_op;
        logic       branch;
        logic [3:0] alu_op;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
    } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_seq_if.sv
// Bundle between the IF/ID side, the controller and the ID/EX consumers.
interface pipe_ctrl_seq_if #(
    parameter int REG_AW = 5
);
    logic [31:0]       id_instr;
    logic              id_valid;
    logic              branch_taken;
    logic [1:0]        pc_src;
    logic              pc_stall;
    logic              if_id_stall;
    logic              if_id_flush;
    logic              ex_reg_wr;
    logic              ex_mem_wr;
    logic              ex_mem_rd;
    logic              ex_alu_src_a;
    logic              ex_alu_src_b;
    logic              ex_ext_op;
    logic              ex_lui_op;
    logic              ex_branch;
    logic [3:0]        ex_alu_op;
    logic [1:0]        ex_mem_to_reg;
    logic [1:0]        ex_reg_dst;
    logic [REG_AW-1:0] ex_rt;
    logic              md_start;
    logic [1:0]        md_op;
    logic              md_busy;

    modport master (
        output id_instr, id_valid, branch_taken,
        input  pc_src, pc_stall, if_id_stall, if_id_flush,
        input  ex_reg_wr, ex_mem_wr, ex_mem_rd, ex_alu_src_a, ex_alu_src_b,
        input  ex_ext_op, ex_lui_op, ex_branch, ex_alu_op, ex_mem_to_reg,
        input  ex_reg_dst, ex_rt, md_start, md_op, md_busy
    );

    modport slave (
        input  id_instr, id_valid, branch_taken,
        output pc_src, pc_stall, if_id_stall, if_id_flush,
        output ex_reg_wr, ex_mem_wr, ex_mem_rd, ex_alu_src_a, ex_alu_src_b,
        output ex_ext_op, ex_lui_op, ex_branch, ex_alu_op, ex_mem_to_reg,
        output ex_reg_dst, ex_rt, md_start, md_op, md_busy
    );
endinterface

// File: rtl/pipe_ctrl_seq_decode.sv
// Pure combinational opcode/funct decoder producing the control bundle and
// the hazard-relevant classification of the ID instruction.
module pipe_ctrl_seq_decode
    import pipe_ctrl_seq_pkg::*;
(
    input  logic       i_valid,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output ctrl_t      o_ctrl,
    output logic       o_known,
    output logic       o_uses_rt,
    output logic       o_is_md,
    output logic       o_is_mfhilo,
    output logic [1:0] o_jump_src
);

    always_comb begin
        o_ctrl      = '0;
        o_known     = 1'b0;
        o_uses_rt   = 1'b0;
        o_is_md     = 1'b0;
        o_is_mfhilo = 1'b0;
        o_jump_src  = PC_SRC_PC4;
        if (i_valid) begin
            o_known = 1'b1;
            case (i_opcode)
                OP_RTYPE: begin
                    o_is_md             = (i_funct[5:2] == FN_MD_HI);
                    o_is_mfhilo         = (i_funct == FN_MFHI) || (i_funct == FN_MFLO);
                    o_ctrl.reg_wr       = !((i_funct == FN_JR) || (i_funct[5:2] == FN_MD_HI));
                    o_ctrl.reg_dst      = REGDST_RD;
                    o_ctrl.alu_op[2:0]  = 3'b010;
                    o_ctrl.alu_src_a    = (i_funct == FN_SLL) || (i_funct == FN_SRL) ||
                                          (i_funct == FN_SRA);
                    o_uses_rt           = 1'b1;
                    if (i_funct == FN_JR) begin
                        o_jump_src = PC_SRC_JREG;
                    end else if (i_funct == FN_JALR) begin
                        o_jump_src        = PC_SRC_JREG;
                        o_ctrl.mem_to_reg = MEM2REG_PC8;
                    end
                end
                OP_J: begin
                    o_jump_src = PC_SRC_JUMP;
                end
                OP_JAL: begin
                    o_jump_src        = PC_SRC_JUMP;
                    o_ctrl.reg_wr     = 1'b1;
                    o_ctrl.reg_dst    = REGDST_RA;
                    o_ctrl.mem_to_reg = MEM2REG_PC8;
                end
                OP_BEQ: begin
                    o_ctrl.branch      = 1'b1;
                    o_ctrl.alu_op[2:0] = 3'b001;
                    o_uses_rt          = 1'b1;
                end
                OP_ADDI, OP_ADDIU: begin
                    o_ctrl.reg_wr    = 1'b1;
                    o_ctrl.alu_src_b = 1'b1;
                end
                OP_SLTI, OP_SLTIU: begin
                    o_ctrl.reg_wr      = 1'b1;
                    o_ctrl.alu_src_b   = 1'b1;
                    o_ctrl.alu_op[2:0] = 3'b101;
                end
                OP_ANDI: begin
                    o_ctrl.reg_wr      = 1'b1;
                    o_ctrl.alu_src_b   = 1'b1;
                    o_ctrl.alu_op[2:0] = 3'b100;
                end
                OP_LUI: begin
                    o_ctrl.reg_wr    = 1'b1;
                    o_ctrl.alu_src_b = 1'b1;
                    o_ctrl.lui_op    = 1'b1;
                end
                OP_LW: begin
                    o_ctrl.reg_wr     = 1'b1;
                    o_ctrl.alu_src_b  = 1'b1;
                    o_ctrl.mem_rd     = 1'b1;
                    o_ctrl.mem_to_reg = MEM2REG_MEM;
                end
                OP_SW: begin
                    o_ctrl.alu_src_b = 1'b1;
                    o_ctrl.mem_wr    = 1'b1;
                    o_uses_rt        = 1'b1;
                end
                default: begin
                    o_known = 1'b0;
                end
            endcase
            // Fields common to every recognised instruction; unknown ones stay a bubble
            if (o_known) begin
                o_ctrl.ext_op    = (i_opcode != OP_ANDI);
                o_ctrl.alu_op[3] = i_opcode[0];
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl_seq.sv
// ID-stage controller: decode, ID/EX control register, load-use / HI-LO stall,
// branch/jump redirect and the multi-cycle mult/div occupancy tracker.
module pipe_ctrl_seq
    import pipe_ctrl_seq_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int REG_AW     = 5
) (
    input  logic            clk,
    input  logic            reset,
    pipe_ctrl_seq_if.slave  bus
);

    localparam int                 CNT_W    = $clog2(MULDIV_LAT + 1);
    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(MULDIV_LAT - 1);

    ctrl_t             w_dec;
    logic              w_known;
    logic              w_uses_rt;
    logic              w_is_md;
    logic              w_is_mfhilo;
    logic [1:0]        w_jump_src;
    logic [REG_AW-1:0] w_rs;
    logic [REG_AW-1:0] w_rt;
    logic              w_hz_lu;
    logic              w_hz_md;
    logic              w_stall;
    logic              w_load_md;
    ctrl_t             w_ctrl_p0;
    logic [REG_AW-1:0] w_rt_p0;
    logic [1:0]        w_pc_src;
    logic              w_flush;
    logic              w_unused;

    ctrl_t             r_ctrl_p1;
    logic [REG_AW-1:0] r_rt_p1;

    md_state_e         r_md_state;
    md_state_e         w_md_state_nx;
    logic [CNT_W-1:0]  r_md_cnt;
    logic [CNT_W-1:0]  w_md_cnt_nx;
    logic              r_md_start;
    logic [1:0]        r_md_op;

    pipe_ctrl_seq_decode u_decode (
        .i_valid     (bus.id_valid),
        .i_opcode    (bus.id_instr[31:26]),
        .i_funct     (bus.id_instr[5:0]),
        .o_ctrl      (w_dec),
        .o_known     (w_known),
        .o_uses_rt   (w_uses_rt),
        .o_is_md     (w_is_md),
        .o_is_mfhilo (w_is_mfhilo),
        .o_jump_src  (w_jump_src)
    );

    assign w_rs     = bus.id_instr[21 +: REG_AW];
    assign w_rt     = bus.id_instr[16 +: REG_AW];
    assign w_unused = ^bus.id_instr[15:6];

    // A load targeting $zero never produces a value worth waiting for
    assign w_hz_lu = r_ctrl_p1.mem_rd && (r_rt_p1 != '0) && w_known &&
                     ((r_rt_p1 == w_rs) || ((r_rt_p1 == w_rt) && w_uses_rt));
    assign w_hz_md = (r_md_state == MD_BUSY) && (w_is_md || w_is_mfhilo);
    assign w_stall = w_hz_lu || w_hz_md;

    // Redirect priority: taken branch kills ID, then stalls, then jumps
    always_comb begin
        w_pc_src        = PC_SRC_PC4;
        w_flush         = 1'b0;
        bus.pc_stall    = 1'b0;
        bus.if_id_stall = 1'b0;
        w_ctrl_p0       = w_dec;
        w_rt_p0         = w_known ? w_rt : '0;
        w_load_md       = w_is_md;
        if (bus.branch_taken) begin
            w_pc_src  = PC_SRC_BRANCH;
            w_flush   = 1'b1;
            w_ctrl_p0 = '0;
            w_rt_p0   = '0;
            w_load_md = 1'b0;
        end else if (w_stall) begin
            bus.pc_stall    = 1'b1;
            bus.if_id_stall = 1'b1;
            w_ctrl_p0       = '0;
            w_rt_p0         = '0;
            w_load_md       = 1'b0;
        end else if (w_jump_src != PC_SRC_PC4) begin
            w_pc_src = w_jump_src;
            w_flush  = 1'b1;
        end
    end

    assign bus.pc_src      = w_pc_src;
    assign bus.if_id_flush = w_flush;

    // ID -> EX boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl_p1 <= '0;
            r_rt_p1   <= '0;
        end else begin
            r_ctrl_p1 <= w_ctrl_p0;
            r_rt_p1   <= w_rt_p0;
        end
    end

    assign bus.ex_reg_wr     = r_ctrl_p1.reg_wr;
    assign bus.ex_mem_wr     = r_ctrl_p1.mem_wr;
    assign bus.ex_mem_rd     = r_ctrl_p1.mem_rd;
    assign bus.ex_alu_src_a  = r_ctrl_p1.alu_src_a;
    assign bus.ex_alu_src_b  = r_ctrl_p1.alu_src_b;
    assign bus.ex_ext_op     = r_ctrl_p1.ext_op;
    assign bus.ex_lui_op     = r_ctrl_p1.lui_op;
    assign bus.ex_branch     = r_ctrl_p1.branch;
    assign bus.ex_alu_op     = r_ctrl_p1.alu_op;
    assign bus.ex_mem_to_reg = r_ctrl_p1.mem_to_reg;
    assign bus.ex_reg_dst    = r_ctrl_p1.reg_dst;
    assign bus.ex_rt         = r_rt_p1;

    // HI/LO occupancy: a taken branch does not abort an operation already issued
    always_comb begin
        w_md_state_nx = r_md_state;
        w_md_cnt_nx   = r_md_cnt;
        case (r_md_state)
            MD_IDLE: begin
                if (w_load_md) begin
                    w_md_cnt_nx   = CNT_INIT;
                    w_md_state_nx = (CNT_INIT == '0) ? MD_IDLE : MD_BUSY;
                end
            end
            MD_BUSY: begin
                w_md_cnt_nx = r_md_cnt - CNT_W'(1);
                if (r_md_cnt <= CNT_W'(1)) begin
                    w_md_state_nx = MD_IDLE;
                end
            end
            default: begin
                w_md_state_nx = MD_IDLE;
                w_md_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_state <= MD_IDLE;
            r_md_cnt   <= '0;
            r_md_start <= 1'b0;
            r_md_op    <= 2'b00;
        end else begin
            r_md_state <= w_md_state_nx;
            r_md_cnt   <= w_md_cnt_nx;
            r_md_start <= w_load_md;
            if (w_load_md) begin
                r_md_op <= bus.id_instr[1:0];
            end
        end
    end

    assign bus.md_start = r_md_start;
    assign bus.md_op    = r_md_op;
    assign bus.md_busy  = (r_md_state == MD_BUSY);

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Directed bench for pipe_ctrl_seq with a per-cycle reference model of the controller.
module tb_pipe_ctrl_seq;

    localparam int LAT = 4;

    localparam logic [31:0] I_LW_T0   = 32'h8FA80000; // lw   $t0,0($sp)
    localparam logic [31:0] I_ADD_T0  = 32'h010A4820; // add  $t1,$t0,$t2
    localparam logic [31:0] I_LW_Z    = 32'h8FA00000; // lw   $0,0($sp)
    localparam logic [31:0] I_ADD_Z   = 32'h00004820; // add  $t1,$0,$0
    localparam logic [31:0] I_MULT    = 32'h01090018; // mult $t0,$t1
    localparam logic [31:0] I_DIVU    = 32'h0109001B; // divu $t0,$t1
    localparam logic [31:0] I_MFLO    = 32'h00005012; // mflo $t2
    localparam logic [31:0] I_JAL     = 32'h0C000010; // jal  0x0040
    localparam logic [31:0] I_SLTIU   = 32'h2C080005;
    localparam logic [31:0] I_ANDI    = 32'h30080005;

    typedef struct packed {
        logic       reg_wr, mem_wr, mem_rd, src_a, src_b, ext, lui, br;
        logic [3:0] aluop;
        logic [1:0] m2r, rdst;
        logic [4:0] rt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    pipe_ctrl_seq_if #(.REG_AW(5)) bus ();

    pipe_ctrl_seq #(.MULDIV_LAT(LAT), .REG_AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic known_op(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a, 6'h0b,
                          6'h0c, 6'h0f, 6'h23, 6'h2b};
    endfunction

    function automatic exp_t dec_model(input logic [31:0] ins, input logic v);
        exp_t       e;
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        e  = '0;
        if (v && known_op(op)) begin
            e.reg_wr = (op == 6'h00) ? !(fn inside {6'h08, 6'h18, 6'h19, 6'h1a, 6'h1b})
                                     : (op inside {6'h03, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f, 6'h23});
            e.mem_wr = (op == 6'h2b);
            e.mem_rd = (op == 6'h23);
            e.src_a  = (op == 6'h00) && (fn inside {6'h00, 6'h02, 6'h03});
            e.src_b  = op inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f, 6'h23, 6'h2b};
            e.ext    = (op != 6'h0c);
            e.lui    = (op == 6'h0f);
            e.br     = (op == 6'h04);
            e.aluop  = {op[0], (op == 6'h00) ? 3'b010 : (op == 6'h04) ? 3'b001 :
                               (op == 6'h0c) ? 3'b100 : (op inside {6'h0a, 6'h0b}) ? 3'b101 : 3'b000};
            e.m2r    = (op == 6'h23) ? 2'd1 : ((op == 6'h03) || (op == 6'h00 && fn == 6'h09)) ? 2'd2 : 2'd0;
            e.rdst   = (op == 6'h00) ? 2'd1 : (op == 6'h03) ? 2'd2 : 2'd0;
            e.rt     = ins[20:16];
        end
        return e;
    endfunction

    // Reference model state
    exp_t       m_ex = '0;
    logic       m_start = 1'b0;
    logic [1:0] m_op = 2'b00;
    int         m_cyc = 0;
    int         m_busy_end = -1;

    exp_t       e_dec, e_nx, got_ex;
    logic [5:0] c_op, c_fn;
    logic       c_known, c_busy, c_lu, c_md, c_ld;
    logic [1:0] c_pc, c_jmp;
    logic       c_stall, c_flush;

    always begin
        @(negedge clk);
        if (!reset) begin
            m_ex = '0; m_start = 1'b0; m_op = 2'b00; m_busy_end = -1;
        end
        c_op    = bus.id_instr[31:26];
        c_fn    = bus.id_instr[5:0];
        c_known = bus.id_valid && known_op(c_op);
        c_busy  = (m_cyc <= m_busy_end);
        e_dec   = dec_model(bus.id_instr, bus.id_valid);
        c_jmp   = !c_known ? 2'd0 : (c_op inside {6'h02, 6'h03}) ? 2'd2 :
                  (c_op == 6'h00 && (c_fn inside {6'h08, 6'h09})) ? 2'd3 : 2'd0;
        c_lu    = m_ex.mem_rd && (m_ex.rt != 5'd0) && c_known &&
                  ((m_ex.rt == bus.id_instr[25:21]) ||
                   ((m_ex.rt == bus.id_instr[20:16]) && (c_op inside {6'h00, 6'h04, 6'h2b})));
        c_md    = c_busy && c_known && (c_op == 6'h00) &&
                  (c_fn inside {6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b});
        c_pc = 2'd0; c_stall = 1'b0; c_flush = 1'b0; e_nx = e_dec;
        if (bus.branch_taken) begin
            c_pc = 2'd1; c_flush = 1'b1; e_nx = '0;
        end else if (c_lu || c_md) begin
            c_stall = 1'b1; e_nx = '0;
        end else if (c_jmp != 2'd0) begin
            c_pc = c_jmp; c_flush = 1'b1;
        end
        c_ld = !bus.branch_taken && !(c_lu || c_md) && c_known && (c_op == 6'h00) &&
               (c_fn inside {6'h18, 6'h19, 6'h1a, 6'h1b});

        got_ex = {bus.ex_reg_wr, bus.ex_mem_wr, bus.ex_mem_rd, bus.ex_alu_src_a, bus.ex_alu_src_b,
                  bus.ex_ext_op, bus.ex_lui_op, bus.ex_branch, bus.ex_alu_op, bus.ex_mem_to_reg,
                  bus.ex_reg_dst, bus.ex_rt};
        chk("model ex bundle", 32'(got_ex), 32'(m_ex));
        chk("model pc_src", 32'(bus.pc_src), 32'(c_pc));
        chk("model pc_stall", 32'(bus.pc_stall), 32'(c_stall));
        chk("model if_id_stall", 32'(bus.if_id_stall), 32'(c_stall));
        chk("model if_id_flush", 32'(bus.if_id_flush), 32'(c_flush));
        chk("model md_start", 32'(bus.md_start), 32'(m_start));
        chk("model md_op", 32'(bus.md_op), 32'(m_op));
        chk("model md_busy", 32'(bus.md_busy), 32'(c_busy));

        @(posedge clk);
        if (reset) begin
            m_ex    = e_nx;
            m_start = c_ld;
            if (c_ld) begin
                m_op       = c_fn[1:0];
                m_busy_end = m_cyc + LAT - 1;
            end
        end
        m_cyc++;
    end

    task automatic drive(input logic [31:0] ins, input logic v, input logic bt);
        @(posedge clk);
        #1;
        bus.id_instr     = ins;
        bus.id_valid     = v;
        bus.branch_taken = bt;
        #1;
    endtask

    int stalls, starts, busys;
    logic [31:0] table_ins [14] = '{
        32'h20080005, 32'h24080005, 32'h28080005, 32'h2C080005, 32'h30080005, 32'h3C081234,
        32'hAFA80000, 32'h11090004, 32'h08000010, 32'h03E00008, 32'h0100F809, 32'h00084880,
        32'hFC000000, 32'h11090004
    };

    initial begin
        bus.id_instr     = 32'h0;
        bus.id_valid     = 1'b0;
        bus.branch_taken = 1'b0;
        #12;
        chk("reset ex_reg_wr", 32'(bus.ex_reg_wr), 32'd0);
        chk("reset md_busy", 32'(bus.md_busy), 32'd0);
        chk("reset md_start", 32'(bus.md_start), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // load-use on $t0
        drive(I_LW_T0, 1'b1, 1'b0);
        drive(I_ADD_T0, 1'b1, 1'b0);
        chk("lu pc_stall", 32'(bus.pc_stall), 32'd1);
        chk("lu if_id_stall", 32'(bus.if_id_stall), 32'd1);
        chk("lu pc_src", 32'(bus.pc_src), 32'd0);
        drive(I_ADD_T0, 1'b1, 1'b0);
        chk("lu bubble reg_wr", 32'(bus.ex_reg_wr), 32'd0);
        chk("lu released", 32'(bus.pc_stall), 32'd0);
        drive(32'h0, 1'b0, 1'b0);
        chk("lu add issued", 32'(bus.ex_reg_wr), 32'd1);
        chk("lu add reg_dst", 32'(bus.ex_reg_dst), 32'd1);

        // load to $zero never stalls
        drive(I_LW_Z, 1'b1, 1'b0);
        drive(I_ADD_Z, 1'b1, 1'b0);
        chk("zero no stall", 32'(bus.pc_stall), 32'd0);

        // taken branch beats a pending load-use
        drive(I_LW_T0, 1'b1, 1'b0);
        drive(I_ADD_T0, 1'b1, 1'b1);
        chk("br pc_src", 32'(bus.pc_src), 32'd1);
        chk("br flush", 32'(bus.if_id_flush), 32'd1);
        chk("br no stall", 32'(bus.pc_stall), 32'd0);
        drive(32'h0, 1'b0, 1'b0);
        chk("br bubble", 32'(bus.ex_reg_wr), 32'd0);

        // mult then mflo
        drive(I_MULT, 1'b1, 1'b0);
        stalls = 0; starts = 0; busys = 0;
        for (int k = 0; k < 6; k++) begin
            drive(I_MFLO, 1'b1, 1'b0);
            if (k == 0) chk("mult md_op", 32'(bus.md_op), 32'd0);
            stalls += int'(bus.pc_stall);
            starts += int'(bus.md_start);
            busys  += int'(bus.md_busy);
        end
        chk("mflo stall cycles", 32'(stalls), 32'd3);
        chk("md_start pulses", 32'(starts), 32'd1);
        chk("md_busy cycles", 32'(busys), 32'd3);

        // jal
        drive(I_JAL, 1'b1, 1'b0);
        chk("jal pc_src", 32'(bus.pc_src), 32'd2);
        chk("jal flush", 32'(bus.if_id_flush), 32'd1);
        drive(32'h0, 1'b0, 1'b0);
        chk("jal reg_dst", 32'(bus.ex_reg_dst), 32'd2);
        chk("jal mem_to_reg", 32'(bus.ex_mem_to_reg), 32'd2);
        chk("jal reg_wr", 32'(bus.ex_reg_wr), 32'd1);

        // assorted opcodes, checked by the model each cycle
        for (int i = 0; i < 14; i++) begin
            drive(table_ins[i], (i != 13), 1'b0);
        end
        drive(I_SLTIU, 1'b1, 1'b0);
        drive(I_ANDI, 1'b1, 1'b0);
        chk("sltiu alu_op", 32'(bus.ex_alu_op), 32'hD);
        drive(32'h0, 1'b0, 1'b0);
        chk("andi alu_op", 32'(bus.ex_alu_op), 32'h4);
        chk("andi ext_op", 32'(bus.ex_ext_op), 32'd0);
        chk("andi alu_src_b", 32'(bus.ex_alu_src_b), 32'd1);

        // async reset mid-busy and mid-stall
        drive(I_DIVU, 1'b1, 1'b0);
        drive(I_LW_T0, 1'b1, 1'b0);
        chk("divu md_start", 32'(bus.md_start), 32'd1);
        chk("divu md_op", 32'(bus.md_op), 32'd3);
        drive(I_ADD_T0, 1'b1, 1'b0);
        chk("pre-reset stall", 32'(bus.pc_stall), 32'd1);
        chk("pre-reset busy", 32'(bus.md_busy), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("rst ex_mem_rd", 32'(bus.ex_mem_rd), 32'd0);
        chk("rst ex_reg_wr", 32'(bus.ex_reg_wr), 32'd0);
        chk("rst md_busy", 32'(bus.md_busy), 32'd0);
        chk("rst pc_stall", 32'(bus.pc_stall), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        drive(32'h0, 1'b0, 1'b0);
        chk("post-rst md_start", 32'(bus.md_start), 32'd0);
        chk("post-rst md_busy", 32'(bus.md_busy), 32'd0);
        drive(32'h0, 1'b0, 1'b0);
        drive(32'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
